// File: rtl/carry_select_subtractor_seq.sv
// Sequential a - b, one SLICE-bit slice per clock, LSB first. Each slice is
// precomputed for both incoming carries and the registered carry picks one.

module csel_sub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] nb,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, nb} + {{SLICE{1'b0}}, cin};
endmodule

module carry_select_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);
  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  logic [WIDTH-1:0]       opa, opnb;
  logic                   carry;
  logic [IW-1:0]          idx;
  logic [SLICE-1:0]       sa, snb, sel_sum;
  logic [1:0][SLICE-1:0]  cand_sum;
  logic [1:0]             cand_c;
  logic                   sel_c, last;

  assign sa  = opa[idx*SLICE +: SLICE];
  assign snb = opnb[idx*SLICE +: SLICE];

  // candidate 0 assumes carry-in 0, candidate 1 assumes carry-in 1
  for (genvar i = 0; i < 2; i++) begin : g_cand
    csel_sub_slice #(.SLICE(SLICE)) u_slice (
      .a    (sa),
      .nb   (snb),
      .cin  (i == 1),
      .sum  (cand_sum[i]),
      .cout (cand_c[i])
    );
  end

  assign sel_sum   = cand_sum[carry];
  assign sel_c     = cand_c[carry];
  assign last      = (idx == IW'(NSL - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opa      <= '0;
      opnb     <= '0;
      carry    <= 1'b1;
      idx      <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opa   <= a;
          opnb  <= ~b;
          carry <= 1'b1;   // +1 of the two's-complement negate
          idx   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          diff[idx*SLICE +: SLICE] <= sel_sum;
          carry <= sel_c;
          idx   <= idx + 1'b1;
          if (last) begin
            state    <= DONE;
            borrow   <= ~sel_c;
            // opnb holds ~b, so equal MSBs mean a and b signs differ
            overflow <= (opa[WIDTH-1] == opnb[WIDTH-1]) &&
                        (sel_sum[SLICE-1] != opa[WIDTH-1]);
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_carry_select_subtractor_seq.sv
// Scoreboard bench: driver pushes expected results on acceptance, monitor pops
// and compares on every output handshake.

module tb_carry_select_subtractor_seq;
  logic        clk = 0, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, diff;
  logic        borrow, overflow;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errs = 0, popped = 0, pushed = 0;
  bit   rand_ready = 0;

  carry_select_subtractor_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    e.d  = x - y;
    e.bo = (x < y);
    e.ov = (x[15] != y[15]) && (e.d[15] != x[15]);
    return e;
  endfunction

  // monitor: out_ready/out_valid are stable at the falling edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_result: got diff=%h borrow=%b ovf=%b with empty scoreboard",
                 diff, borrow, overflow);
      end else begin
        exp_t e;
        e = sb.pop_front();
        popped++;
        if ({diff, borrow, overflow} !== e) begin
          errs++;
          $display("FAIL result: got diff=%h borrow=%b ovf=%b expected diff=%h borrow=%b ovf=%b",
                   diff, borrow, overflow, e.d, e.bo, e.ov);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // call just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [15:0] x, input logic [15:0] y, input exp_t e);
    a = x; b = y; in_valid = 1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        pushed++;
        @(posedge clk); #1;
        in_valid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    for (int t = 0; t < 200 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", sb.size(), 0);
    out_ready = 0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("valid_timeout", out_valid, 1);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0; a = 0; b = 0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // basic + exact latency: valid only after 4th edge following acceptance
    send(16'h1234, 16'h0034, '{16'h1200, 1'b0, 1'b0});
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("latency_k%0d", k), out_valid, (k == 4));
      if (k < 4) chk($sformatf("busy_in_ready_k%0d", k), in_ready, 0);
    end
    @(posedge clk); #1;
    drain();

    send(16'h0000, 16'h0001, '{16'hFFFF, 1'b1, 1'b0}); drain();
    send(16'h8000, 16'h0001, '{16'h7FFF, 1'b0, 1'b1}); drain();
    send(16'h7FFF, 16'hFFFF, '{16'h8000, 1'b1, 1'b1}); drain();
    send(16'hBEEF, 16'hBEEF, '{16'h0000, 1'b0, 1'b0}); drain();

    // back-pressure: outputs hold, in_valid ignored
    send(16'hA5A5, 16'h5A5A, '{16'h4B4B, 1'b0, 1'b1});
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0]; a = 16'h0F0F ^ 16'(k); b = 16'h1111;
      @(negedge clk);
      chk("bp_diff", diff, 16'h4B4B);
      chk("bp_flags", {borrow, overflow}, 2'b01);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_diff_hold", diff, 16'h4B4B);
    @(posedge clk); #1;
    send(16'h0010, 16'h0001, '{16'h000F, 1'b0, 1'b0}); drain();

    // reset in the second BUSY cycle
    send(16'h1111, 16'h2222, '{16'hEEEF, 1'b1, 1'b0});
    @(posedge clk); #1;
    rst_n = 0; #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_borrow", borrow, 0);
    sb.delete(); pushed--;
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    send(16'h00FF, 16'h00FF, '{16'h0000, 1'b0, 1'b0}); drain();

    // back-to-back random with random out_ready
    rand_ready = 1;
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] x, y;
      x = 16'($urandom); y = 16'($urandom);
      if (n % 50 == 0) y = x;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(x, y, model(x, y));
    end
    for (int t = 0; t < 500 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    rand_ready = 0;
    #2 out_ready = 0;
    chk("sb_empty", sb.size(), 0);
    chk("result_count", popped, pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
